// File: rtl/squarer_pipe_acc.sv
`default_nettype none
// ============================================================================
// squarer_pipe_acc : pipelined signed/unsigned squarer, valid/ready handshake,
//                    saturating sum-of-squares accumulate mode.
// Revision: 1.0
// ============================================================================
module squarer_pipe_acc #(
  parameter int DATA_WIDTH = 40,
  parameter int PIPELINE   = 3,
  parameter int ACC_WIDTH  = 88
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  signed_mode,
  input  logic                  acc_en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] dataa,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  sat
);
  localparam int c_sq_width = 2 * DATA_WIDTH;

  generate
    if (ACC_WIDTH < 2 * DATA_WIDTH || DATA_WIDTH < 2 || DATA_WIDTH > 64 ||
        PIPELINE < 1 || PIPELINE > 8) begin : g_param_check
      $error("squarer_pipe_acc: illegal DATA_WIDTH/PIPELINE/ACC_WIDTH combination");
    end
  endgenerate

  logic                  w_stall;
  logic                  w_neg;
  logic [DATA_WIDTH-1:0] w_mag;
  logic [c_sq_width-1:0] w_sq;
  logic                  w_fin_valid;
  logic                  w_fin_acc;
  logic                  w_fin_last;
  logic [c_sq_width-1:0] w_fin_sq;
  logic                  out_valid_q;

  assign w_stall  = out_valid_q && !out_ready;
  assign in_ready = !w_stall;

  // Square the magnitude; -2^(W-1) maps to an unsigned 2^(W-1) which still fits.
  always_comb begin
    w_neg = signed_mode && dataa[DATA_WIDTH-1];
    w_mag = w_neg ? (~dataa + DATA_WIDTH'(1)) : dataa;
    w_sq  = c_sq_width'(w_mag) * c_sq_width'(w_mag);
  end

  generate
    if (PIPELINE > 1) begin : g_pipe
      localparam int c_depth = PIPELINE - 1;
      logic [c_depth-1:0]    vld_q, vld_d, en_q, en_d, last_q, last_d;
      logic [c_sq_width-1:0] sq_q [c_depth];
      logic [c_sq_width-1:0] sq_d [c_depth];

      always_comb begin
        vld_d  = vld_q;
        en_d   = en_q;
        last_d = last_q;
        sq_d   = sq_q;
        if (!w_stall) begin
          vld_d[0]  = in_valid;
          en_d[0]   = acc_en;
          last_d[0] = in_last;
          sq_d[0]   = w_sq;
          for (int i = 1; i < c_depth; i++) begin
            vld_d[i]  = vld_q[i-1];
            en_d[i]   = en_q[i-1];
            last_d[i] = last_q[i-1];
            sq_d[i]   = sq_q[i-1];
          end
        end
      end

      always_ff @(posedge clock) begin
        if (!reset_n) begin
          vld_q <= '0;
        end else begin
          vld_q <= vld_d;
        end
        en_q   <= en_d;
        last_q <= last_d;
        sq_q   <= sq_d;
      end

      assign w_fin_valid = vld_q[c_depth-1];
      assign w_fin_acc   = en_q[c_depth-1];
      assign w_fin_last  = last_q[c_depth-1];
      assign w_fin_sq    = sq_q[c_depth-1];
    end else begin : g_direct
      assign w_fin_valid = in_valid;
      assign w_fin_acc   = acc_en;
      assign w_fin_last  = in_last;
      assign w_fin_sq    = w_sq;
    end
  endgenerate

  logic                 out_valid_d, sat_q, sat_d, sticky_q, sticky_d;
  logic [ACC_WIDTH-1:0] result_q, result_d, acc_q, acc_d;
  logic [ACC_WIDTH-1:0] w_sq_ext, w_sum_sat;
  logic [ACC_WIDTH:0]   w_sum;
  logic                 w_ovf;

  always_comb begin
    w_sq_ext  = ACC_WIDTH'(w_fin_sq);
    w_sum     = {1'b0, acc_q} + {1'b0, w_sq_ext};
    w_ovf     = w_sum[ACC_WIDTH];
    w_sum_sat = w_ovf ? '1 : w_sum[ACC_WIDTH-1:0];
  end

  // Final stage: emits squares directly, or folds them into the frame sum.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    sat_d       = sat_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    if (!w_stall) begin
      out_valid_d = 1'b0;
      if (w_fin_valid) begin
        if (!w_fin_acc) begin
          result_d    = w_sq_ext;
          sat_d       = 1'b0;
          out_valid_d = 1'b1;
        end else if (w_fin_last) begin
          result_d    = w_sum_sat;
          sat_d       = sticky_q || w_ovf;
          out_valid_d = 1'b1;
          acc_d       = '0;
          sticky_d    = 1'b0;
        end else begin
          acc_d    = w_sum_sat;
          sticky_d = sticky_q || w_ovf;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      sat_q       <= 1'b0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      sat_q       <= sat_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign sat       = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_squarer_pipe_acc.sv
`default_nettype none
// ============================================================================
// tb_squarer_pipe_acc : scoreboard bench for squarer_pipe_acc.
// Revision: 1.0
// ============================================================================
module tb_squarer_pipe_acc;
  localparam int DW = 40;
  localparam int PL = 3;
  localparam int AW = 80;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          signed_mode = 1'b0;
  logic          acc_en = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b1;
  logic [DW-1:0] dataa = '0;
  logic          in_ready;
  logic          out_valid;
  logic          sat;
  logic [AW-1:0] result;

  always #5 clock = ~clock;

  squarer_pipe_acc #(.DATA_WIDTH(DW), .PIPELINE(PL), .ACC_WIDTH(AW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .signed_mode (signed_mode),
    .acc_en      (acc_en),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dataa       (dataa),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .sat         (sat)
  );

  typedef struct {
    logic [AW-1:0] res;
    logic          sat;
    int            cyc;
    logic          lat;
  } exp_t;

  typedef struct {
    logic          sm;
    logic          ae;
    logic          lst;
    logic [DW-1:0] d;
  } beat_t;

  exp_t         sb[$];
  beat_t        stim[200];
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  logic         bp_mode = 1'b0;
  logic [127:0] frame_total = '0;
  logic [127:0] max_v;
  logic [DW-1:0] v_min;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    #1 out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Exact square of the sample as an integer, independent of any hardware form.
  function automatic logic [127:0] sq_model(input logic sm, input logic [DW-1:0] d);
    logic signed [DW:0]     v;
    logic signed [2*DW+1:0] p;
    v = sm ? $signed({d[DW-1], d}) : $signed({1'b0, d});
    p = v * v;
    return 128'(p);
  endfunction

  // Monitor: handshake rule every cycle, scoreboard pop on every transfer.
  always @(negedge clock) begin
    exp_t e;
    checks++;
    if (in_ready !== !(out_valid && !out_ready)) begin
      errors++;
      $display("FAIL in_ready_rule cyc=%0d: in_ready=%b out_valid=%b out_ready=%b", cyc, in_ready, out_valid, out_ready);
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output cyc=%0d: result=%0d sat=%b, none expected", cyc, result, sat);
      end else begin
        e = sb.pop_front();
        if (result !== e.res || sat !== e.sat) begin
          errors++;
          $display("FAIL result cyc=%0d: got result=%0d sat=%b, want result=%0d sat=%b", cyc, result, sat, e.res, e.sat);
        end
        if (e.lat) begin
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL latency: output at cycle %0d, want cycle %0d", cyc, e.cyc);
          end
        end
      end
    end
  end

  task automatic send(input logic sm, input logic ae, input logic lst, input logic [DW-1:0] d);
    bit           done;
    int           acc_cyc;
    logic [127:0] sq;
    logic [127:0] clamp;
    exp_t         e;
    done    = 0;
    acc_cyc = 0;
    signed_mode = sm;
    acc_en      = ae;
    in_last     = lst;
    dataa       = d;
    in_valid    = 1'b1;
    for (int t = 0; t < 1000 && !done; t++) begin
      @(negedge clock);
      if (!bp_mode) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL in_ready_stream cyc=%0d: in_ready=%b, want 1", cyc, in_ready);
        end
      end
      if (in_ready === 1'b1) begin
        done    = 1;
        acc_cyc = cyc;
      end
      @(posedge clock);
      #1;
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout: in_ready=%b, want 1 within 1000 cycles", in_ready);
      return;
    end
    sq = sq_model(sm, d);
    e.cyc = acc_cyc + PL;
    e.lat = !bp_mode;
    if (!ae) begin
      e.res = sq[AW-1:0];
      e.sat = 1'b0;
      sb.push_back(e);
    end else begin
      frame_total += sq;
      if (lst) begin
        clamp = (frame_total > max_v) ? max_v : frame_total;
        e.res = clamp[AW-1:0];
        e.sat = (frame_total > max_v);
        sb.push_back(e);
        frame_total = '0;
      end
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int t = 0; t < 2000 && sb.size() != 0; t++) begin
      @(posedge clock);
      #1;
    end
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout: %0d results outstanding, want 0", sb.size());
    end
    bp_mode = 1'b0;
    repeat (4) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset_n  = 1'b0;
    @(posedge clock);
    #1;
    reset_n     = 1'b1;
    frame_total = '0;
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || result !== '0 || sat !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b result=%0d sat=%b in_ready=%b, want 0 0 0 1", out_valid, result, sat, in_ready);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic run_stim();
    for (int i = 0; i < 200; i++) send(stim[i].sm, stim[i].ae, stim[i].lst, stim[i].d);
  endtask

  initial begin
    max_v = (128'd1 << AW) - 128'd1;
    v_min = {1'b1, {(DW-1){1'b0}}};
    repeat (2) @(posedge clock);
    #1;
    do_reset();

    // Signed corners, then unsigned all-ones.
    send(1'b1, 1'b0, 1'b0, v_min);
    send(1'b1, 1'b0, 1'b0, '1);
    send(1'b1, 1'b0, 1'b0, '0);
    send(1'b0, 1'b0, 1'b0, '1);
    drain();

    // Back-to-back random signed squares.
    for (int i = 0; i < 100; i++) send(1'b1, 1'b0, 1'b0, DW'({$urandom(), $urandom()}));
    drain();

    // Mixed stream, first without stalls, then the same beats under backpressure.
    for (int i = 0; i < 200; i++) begin
      stim[i].sm  = 1'($urandom_range(0, 1));
      stim[i].ae  = 1'($urandom_range(0, 1));
      stim[i].lst = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0:       stim[i].d = v_min;
        1:       stim[i].d = '1;
        default: stim[i].d = DW'({$urandom(), $urandom()});
      endcase
    end
    stim[199].ae  = 1'b1;
    stim[199].lst = 1'b1;
    run_stim();
    drain();
    bp_mode = 1'b1;
    run_stim();
    drain();

    // Accumulate frames, interleaving, and saturation.
    send(1'b1, 1'b1, 1'b0, DW'(3));
    send(1'b1, 1'b1, 1'b0, DW'(-4));
    send(1'b1, 1'b1, 1'b1, DW'(12));
    send(1'b1, 1'b1, 1'b1, DW'(5));
    send(1'b1, 1'b1, 1'b0, DW'(6));
    send(1'b0, 1'b0, 1'b0, DW'(7));
    send(1'b1, 1'b1, 1'b1, DW'(-8));
    for (int i = 0; i < 4; i++) send(1'b1, 1'b1, (i == 3), v_min);
    drain();

    // Reset in the middle of a frame discards the partial sum.
    send(1'b1, 1'b1, 1'b0, DW'(7));
    send(1'b1, 1'b1, 1'b0, DW'(9));
    do_reset();
    send(1'b1, 1'b1, 1'b1, DW'(2));
    drain();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected results never seen, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
